// File: rtl/avg_pkg.sv
// Shared constants and FSM state type for the averaged-pixel stream packer.
package avg_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned COLS          = 8;
  localparam int unsigned ROWS          = 15;
  localparam int unsigned PIX_PER_FRAME = COLS * ROWS;
  localparam int unsigned ROW_W         = 4;
  localparam int unsigned COL_W         = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } pack_state_t;

endpackage

// File: rtl/avg_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO with no pop is dropped and flagged.
module avg_sync_fifo
  import avg_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              drop_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & full & ~do_pop;

  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/avg_stream_packer.sv
// Buffers the averager's unthrottled pixel stream and re-emits it framed on a ready/valid port.
// Optional frame XOR checksum enabled by defining AVG_PACK_CHECKSUM_EN.
module avg_stream_packer
  import avg_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof,
  output logic              frame_done,
  output logic              overflow,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [COL_W-1:0] LastCol = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(ROWS - 1);

  logic             hs, drop;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             overflow_q, overflow_d;
  pack_state_t      state_q, state_d;

  avg_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .drop_o  (drop)
  );

  assign hs       = out_valid & out_ready;
  assign out_row  = row_q;
  assign out_col  = col_q;
  assign out_sol  = (col_q == '0);
  assign out_eol  = (col_q == LastCol);
  assign out_eof  = out_eol & (row_q == LastRow);
  assign overflow = overflow_q;

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    overflow_d = overflow_q | drop;
    if (hs) begin
      if (out_eof) begin
        row_d = '0;
        col_d = '0;
      end else if (out_eol) begin
        row_d = row_q + ROW_W'(1);
        col_d = '0;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q      <= '0;
      col_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      overflow_q <= overflow_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (hs) state_d = S_ACTIVE;
      S_ACTIVE: if (hs && out_eof) state_d = S_DONE;
      S_DONE:   state_d = hs ? S_ACTIVE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    frame_done = 1'b0;
    if (state_q == S_DONE) frame_done = 1'b1;
  end

`ifdef AVG_PACK_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    acc_d      = acc_q;
    checksum_d = checksum_q;
    if (hs) begin
      if (out_eof) begin
        checksum_d = acc_q ^ out_data;
        acc_d      = '0;
      end else begin
        acc_d = acc_q ^ out_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      checksum_q <= '0;
    end else begin
      acc_q      <= acc_d;
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
